sap_control_seq: RTL and testbench
==================================

// Module: sap_control_seq
// PURPOSE
//  Instruction sequencer/datapath controller of the 16-bit SAP CPU; sits directly upstream of alu.
//  Fetches 16-bit instructions from a sync-read memory, decodes them, fetches memory operands,
//  drives alu operands/opcode, writes back ACC and Z/V flags, and handles jumps, OUT and HLT.
//  Instruction format: [15:12] opcode, [11:0] address/operand field.
// PARAMETERS
//  RESET_PC  12'h000  PC value loaded on reset
// PORTS
//  clk        in   1   single clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  mem_addr   out  12  memory address (combinational from state/PC/IR)
//  mem_rdata  in   16  memory read data, valid the cycle after mem_addr is presented
//  mem_wdata  out  16  write data (= ACC)
//  mem_we     out  1   write strobe, one cycle, written at posedge
//  alu_a      out  16  ALU operand a (= ACC)
//  alu_b      out  16  ALU operand b (= B register)
//  alu_op     out  4   ALU opcode: ADD=0 SUB=1 INC=2 DEC=3 AND=4 OR=5 XOR=6 NOT=7
//  alu_res    in   17  ALU result (combinational)
//  alu_flag   in   2   ALU flags: [0]=zero, [1]=overflow/carry (res[16])
//  out_data   out  16  output port register
//  out_valid  out  1   one-cycle pulse when out_data updated; no backpressure
//  halted     out  1   high while in HALT
// BEHAVIOUR
//  Reset: PC=RESET_PC, IR=0, ACC=0, B=0, Z=0, V=0, out_data=0, out_valid=0, halted=0, state=FETCH.
//   mem_we gated with ~rst: a reset asserted in a STA DECODE cycle suppresses the write.
//   Reset mid-instruction abandons it; no partial ACC/flag update.
//  Opcodes: 0 NOP, 1 LDA a, 2 STA a, 3 ADD a, 4 SUB a, 5 AND a, 6 OR a, 7 XOR a, 8 INC, 9 DEC,
//   A NOT, B JMP a, C JZ a, D JV a, E OUT, F HLT.
//  FSM states and transitions:
//   FETCH   mem_addr=PC -> LOADIR
//   LOADIR  IR<=mem_rdata; PC<=PC+1 (12-bit wrap, FFF->000) -> DECODE
//   DECODE  NOP->FETCH; STA: mem_addr=IR[11:0], mem_we=1 -> FETCH;
//           LDA/ADD/SUB/AND/OR/XOR: -> OPRD; INC/DEC/NOT: -> EXEC;
//           JMP: PC<=IR[11:0]; JZ/JV: PC<=IR[11:0] only if Z/V set, else PC unchanged; -> FETCH;
//           OUT: out_data<=ACC, out_valid=1 next cycle (one cycle) -> FETCH; HLT -> HALT
//   OPRD    mem_addr=IR[11:0] -> OPLD
//   OPLD    LDA: ACC<=mem_rdata, flags unchanged -> FETCH; else B<=mem_rdata -> EXEC
//   EXEC    alu_op from IR: ADD0 SUB1 INC2 DEC3 AND4 OR5 XOR6 NOT7; ACC<=alu_res[15:0],
//           Z<=alu_flag[0], V<=alu_flag[1] -> FETCH
//   HALT    halted=1; PC/ACC/flags frozen; leaves only on rst
//  Latency (cycles): NOP/STA/JMP/Jcc/OUT 3; INC/DEC/NOT 4; LDA 5; ADD..XOR 6.
//  mem_addr = PC outside OPRD/STA-DECODE; alu_b = B always; alu_op held = IR decode in all states.
//  Only ALU ops touch Z/V; LDA, STA, jumps, OUT leave them unchanged. V is alu_res[16] as supplied.
// TESTING
//  1 rst held 2 cycles then released -> mem_addr=000, all outputs 0, first fetch at PC=000.
//  2 mem[0]=1010(LDA 010), mem[1]=3011(ADD 011), mem[2]=E000, [010]=0005,[011]=0007 -> out_data=000C, Z=0, one out_valid pulse.
//  3 LDA FFFF;INC -> ACC=0000, Z=1; then JZ 020 -> next fetch addr 020; JV with V=0 -> falls through.
//  4 ACC=1234; STA 040 -> mem_we high exactly 1 cycle, addr 040, wdata 1234; rst in that cycle -> no write.
//  5 HLT at 005 -> halted=1, mem_we=0, PC frozen 100 cycles; rst -> restarts at RESET_PC.
//  6 JMP FFF with mem[FFF]=9000 (DEC) -> after LOADIR PC wraps to 000; ACC=0 DEC -> FFFF, Z=0.

Source files
------------

// File: rtl/sap_control_seq.sv
// SAP 16-bit CPU sequencer: fetch/decode/operand-fetch/execute FSM that
// drives an external combinational ALU and a sync-read memory.
module sap_control_seq #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [16:0] alu_res,
  input  logic [1:0]  alu_flag,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        halted
);

  typedef enum logic [2:0] {
    FETCH, LOADIR, DECODE, OPRD, OPLD, EXEC, HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2,
                         OP_ADD = 4'h3, OP_SUB = 4'h4, OP_AND = 4'h5,
                         OP_OR  = 4'h6, OP_XOR = 4'h7, OP_INC = 4'h8,
                         OP_DEC = 4'h9, OP_NOT = 4'hA, OP_JMP = 4'hB,
                         OP_JZ  = 4'hC, OP_JV  = 4'hD, OP_OUT = 4'hE,
                         OP_HLT = 4'hF;

  state_t      state;
  logic [11:0] pc;
  logic [15:0] ir, acc, b;
  logic        z, v;
  logic [3:0]  opc;

  assign opc       = ir[15:12];
  assign mem_wdata = acc;
  assign alu_a     = acc;
  assign alu_b     = b;

  // Operand address only in OPRD and STA decode; PC otherwise. Write is
  // killed by reset in the same cycle so an abandoned STA never lands.
  always_comb begin
    mem_addr = pc;
    mem_we   = 1'b0;
    if (state == OPRD) mem_addr = ir[11:0];
    if (state == DECODE && opc == OP_STA) begin
      mem_addr = ir[11:0];
      mem_we   = ~rst;
    end
  end

  // ALU opcode is a pure decode of IR, held steady in every state.
  always_comb begin
    alu_op = 4'd0;
    case (opc)
      OP_ADD:  alu_op = 4'd0;
      OP_SUB:  alu_op = 4'd1;
      OP_INC:  alu_op = 4'd2;
      OP_DEC:  alu_op = 4'd3;
      OP_AND:  alu_op = 4'd4;
      OP_OR:   alu_op = 4'd5;
      OP_XOR:  alu_op = 4'd6;
      OP_NOT:  alu_op = 4'd7;
      default: alu_op = 4'd0;
    endcase
  end

  // Main sequencer: state, architectural registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= 16'h0;
      acc       <= 16'h0;
      b         <= 16'h0;
      z         <= 1'b0;
      v         <= 1'b0;
      out_data  <= 16'h0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        FETCH: state <= LOADIR;
        LOADIR: begin
          ir    <= mem_rdata;
          pc    <= pc + 12'd1;
          state <= DECODE;
        end
        DECODE: begin
          state <= FETCH;
          case (opc)
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state <= OPRD;
            OP_INC, OP_DEC, OP_NOT: state <= EXEC;
            OP_JMP: pc <= ir[11:0];
            OP_JZ:  if (z) pc <= ir[11:0];
            OP_JV:  if (v) pc <= ir[11:0];
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
            end
            OP_HLT: begin
              state  <= HALT;
              halted <= 1'b1;
            end
            default: state <= FETCH;
          endcase
        end
        OPRD: state <= OPLD;
        OPLD: begin
          if (opc == OP_LDA) begin
            acc   <= mem_rdata;
            state <= FETCH;
          end else begin
            b     <= mem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          acc   <= alu_res[15:0];
          z     <= alu_flag[0];
          v     <= alu_flag[1];
          state <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_seq.sv
// Directed bench for sap_control_seq: sync-read memory and ALU models,
// a table of ALU programs, plus hand sequences for STA, HLT, reset and wrap.
module tb_sap_control_seq;

  logic        clk, rst, load;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata, mem_wdata, alu_a, alu_b, out_data;
  logic        mem_we, out_valid, halted;
  logic [3:0]  alu_op;
  logic [16:0] alu_res;
  logic [1:0]  alu_flag;

  logic [15:0] mem [0:4095];
  logic [15:0] img [0:4095];

  int total = 0, bad = 0;
  int ov_cnt, we_cnt;
  logic [15:0] last_out, we_data;
  logic [11:0] we_addr;

  sap_control_seq #(.RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_res(alu_res), .alu_flag(alu_flag),
    .out_data(out_data), .out_valid(out_valid), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: bulk load from img, sync read, write on strobe.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 4096; i++) mem[i] <= img[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // ALU model
  always_comb begin
    alu_res = 17'h0;
    case (alu_op)
      4'd0: alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1: alu_res = {1'b0, alu_a} - {1'b0, alu_b};
      4'd2: alu_res = {1'b0, alu_a} + 17'd1;
      4'd3: alu_res = {1'b0, alu_a} - 17'd1;
      4'd4: alu_res = {1'b0, alu_a & alu_b};
      4'd5: alu_res = {1'b0, alu_a | alu_b};
      4'd6: alu_res = {1'b0, alu_a ^ alu_b};
      4'd7: alu_res = {1'b0, ~alu_a};
      default: alu_res = 17'h0;
    endcase
    alu_flag = {alu_res[16], alu_res[15:0] == 16'h0};
  end

  // Pulse monitor
  always @(negedge clk) begin
    if (rst) begin
      ov_cnt <= 0;
      we_cnt <= 0;
    end else begin
      if (out_valid) begin
        ov_cnt   <= ov_cnt + 1;
        last_out <= out_data;
      end
      if (mem_we) begin
        we_cnt  <= we_cnt + 1;
        we_addr <= mem_addr;
        we_data <= mem_wdata;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 4096; i++) img[i] = 16'h0;
  endtask

  // Reset + load, release, then start running.
  task automatic start_prog();
    rst = 1'b1; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    for (int c = 0; c < 400; c++) begin
      if (halted) break;
      @(posedge clk); #1;
    end
    chk(name, {31'h0, halted}, 32'h1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, exp_out;
    logic [11:0] exp_pc;   // halt PC encodes flags: 006 none, 022 Z, 031 V, 041 Z+V
  } vec_t;

  vec_t vt [10];
  int   frozen_err;

  initial begin
    rst = 1'b1; load = 1'b0;
    vt[0] = '{4'h3, 16'h0005, 16'h0007, 16'h000C, 12'h006};  // ADD
    vt[1] = '{4'h3, 16'hFFFF, 16'h0001, 16'h0000, 12'h041};  // ADD carry
    vt[2] = '{4'h4, 16'h0007, 16'h0007, 16'h0000, 12'h022};  // SUB zero
    vt[3] = '{4'h4, 16'h0003, 16'h0005, 16'hFFFE, 12'h031};  // SUB borrow
    vt[4] = '{4'h5, 16'hF0F0, 16'h0FF0, 16'h00F0, 12'h006};  // AND
    vt[5] = '{4'h6, 16'h1200, 16'h0034, 16'h1234, 12'h006};  // OR
    vt[6] = '{4'h7, 16'hAAAA, 16'hAAAA, 16'h0000, 12'h022};  // XOR
    vt[7] = '{4'h8, 16'hFFFF, 16'h0000, 16'h0000, 12'h041};  // INC wrap
    vt[8] = '{4'h9, 16'h0000, 16'h0000, 16'hFFFF, 12'h031};  // DEC wrap
    vt[9] = '{4'hA, 16'h00FF, 16'h0000, 16'hFF00, 12'h006};  // NOT

    // Reset state
    clear_img();
    load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    @(posedge clk); #1;
    chk("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
    chk("rst_outputs", {13'h0, out_data, out_valid, halted, mem_we}, 32'h0);
    rst = 1'b0;
    chk("first_fetch_addr", {20'h0, mem_addr}, 32'h0);
    @(posedge clk); #1;
    chk("loadir_addr", {20'h0, mem_addr}, 32'h0);

    // ALU program table
    for (int k = 0; k < 10; k++) begin
      clear_img();
      img[12'h000] = 16'h1010;
      img[12'h001] = {vt[k].op, 12'h011};
      img[12'h002] = 16'hE000;
      img[12'h003] = 16'hC020;
      img[12'h004] = 16'hD030;
      img[12'h005] = 16'hF000;
      img[12'h020] = 16'hD040;
      img[12'h021] = 16'hF000;
      img[12'h030] = 16'hF000;
      img[12'h040] = 16'hF000;
      img[12'h010] = vt[k].a;
      img[12'h011] = vt[k].b;
      start_prog();
      wait_halt($sformatf("v%0d_halt", k));
      chk($sformatf("v%0d_out", k), {16'h0, last_out}, {16'h0, vt[k].exp_out});
      chk($sformatf("v%0d_ovcnt", k), ov_cnt, 1);
      chk($sformatf("v%0d_flags_pc", k), {20'h0, mem_addr}, {20'h0, vt[k].exp_pc});
    end

    // LDA FFFF; INC; JZ 020 -> halt fetched at 020
    clear_img();
    img[12'h000] = 16'h1010; img[12'h001] = 16'h8000; img[12'h002] = 16'hC020;
    img[12'h003] = 16'hF000; img[12'h020] = 16'hF000; img[12'h010] = 16'hFFFF;
    start_prog();
    wait_halt("jz_halt");
    chk("jz_taken_pc", {20'h0, mem_addr}, 32'h021);

    // STA: one write of ACC to 040
    clear_img();
    img[12'h000] = 16'h1010; img[12'h001] = 16'h2040; img[12'h002] = 16'hF000;
    img[12'h010] = 16'h1234;
    start_prog();
    wait_halt("sta_halt");
    chk("sta_we_cnt", we_cnt, 1);
    chk("sta_we_addr", {20'h0, we_addr}, 32'h040);
    chk("sta_we_data", {16'h0, we_data}, 32'h1234);
    chk("sta_mem", {16'h0, mem[12'h040]}, 32'h1234);

    // STA with reset in the write cycle
    start_prog();
    for (int c = 0; c < 50; c++) begin
      if (mem_we) break;
      @(posedge clk); #1;
    end
    chk("sta2_we_seen", {31'h0, mem_we}, 32'h1);
    rst = 1'b1; #1;
    chk("sta2_we_gated", {31'h0, mem_we}, 32'h0);
    @(posedge clk); #1;
    chk("sta2_no_write", {16'h0, mem[12'h040]}, 32'h0);
    chk("sta2_reset_pc", {20'h0, mem_addr}, 32'h0);
    rst = 1'b0;

    // HLT at 005: frozen 100 cycles, then reset restarts
    clear_img();
    img[12'h005] = 16'hF000;
    start_prog();
    wait_halt("hlt_halt");
    chk("hlt_pc", {20'h0, mem_addr}, 32'h006);
    frozen_err = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (mem_addr !== 12'h006 || mem_we !== 1'b0 || halted !== 1'b1) frozen_err++;
    end
    chk("hlt_frozen", frozen_err, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("hlt_restart_pc", {20'h0, mem_addr}, 32'h0);
    chk("hlt_cleared", {31'h0, halted}, 32'h0);

    // JMP FFF, DEC at FFF, PC wraps; JV falls through then taken
    clear_img();
    img[12'h000] = 16'hD005; img[12'h001] = 16'hBFFF; img[12'hFFF] = 16'h9000;
    img[12'h005] = 16'hE000; img[12'h006] = 16'hC010; img[12'h007] = 16'hF000;
    start_prog();
    for (int c = 0; c < 50; c++) begin
      if (mem_addr == 12'hFFF) break;
      @(posedge clk); #1;
    end
    chk("wrap_fetch_fff", {20'h0, mem_addr}, 32'hFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wrap_pc_000", {20'h0, mem_addr}, 32'h0);
    wait_halt("wrap_halt");
    chk("wrap_dec_out", {16'h0, last_out}, 32'hFFFF);
    chk("wrap_ovcnt", ov_cnt, 1);
    chk("wrap_final_pc", {20'h0, mem_addr}, 32'h008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
